// File: rtl/sbox_arbiter.sv
// Shares one SBOX lookup unit between the key-expansion (KE) and datapath (DP) requesters.
// Round-robin or KE-priority arbitration with burst locks; results are routed back by tag.
module sbox_arbiter #(
    parameter int SBOX_LAT = 1,
    parameter int KE_PRIO  = 0,
    parameter int MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ke_req,
    input  logic       ke_lock,
    input  logic [7:0] ke_byte,
    input  logic       ke_en_de,
    output logic       ke_gnt,
    output logic       ke_rvalid,
    output logic [7:0] ke_rdata,
    input  logic       dp_req,
    input  logic       dp_lock,
    input  logic [7:0] dp_byte,
    input  logic       dp_en_de,
    output logic       dp_gnt,
    output logic       dp_rvalid,
    output logic [7:0] dp_rdata,
    output logic [7:0] sbox_in,
    output logic       sbox_en_de_in,
    output logic       ce,
    output logic       re,
    input  logic [7:0] sbox_out
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    logic                lock_vld;
    logic                lock_ke;
    logic [7:0]          lock_cnt;
    logic                last_ke;
    logic [SBOX_LAT-1:0] vld_pipe;
    logic [SBOX_LAT-1:0] ke_pipe;

    logic ke_win, dp_win, lock_hold, other_req, gnt_any, gnt_lock;

    always_comb begin
        ke_win    = 1'b0;
        dp_win    = 1'b0;
        other_req = 1'b0;
        lock_hold = lock_vld && (lock_ke ? ke_req : dp_req);
        if (lock_hold) begin
            other_req = lock_ke ? dp_req : ke_req;
            // A saturated lock yields to a waiting requester for one grant.
            if (lock_cnt == MAX_CNT && other_req) begin
                ke_win = !lock_ke;
                dp_win = lock_ke;
            end else begin
                ke_win = lock_ke;
                dp_win = !lock_ke;
            end
        end else if (ke_req && !dp_req) begin
            ke_win = 1'b1;
        end else if (dp_req && !ke_req) begin
            dp_win = 1'b1;
        end else if (ke_req && dp_req) begin
            if (KE_PRIO != 0 || !last_ke) ke_win = 1'b1;
            else                          dp_win = 1'b1;
        end
    end

    assign ke_gnt   = rst_n & ke_win;
    assign dp_gnt   = rst_n & dp_win;
    assign gnt_any  = ke_gnt | dp_gnt;
    assign gnt_lock = ke_gnt ? ke_lock : dp_lock;

    always_comb begin
        sbox_in       = 8'h00;
        sbox_en_de_in = 1'b1;
        if (ke_gnt) begin
            sbox_in       = ke_byte;
            sbox_en_de_in = ke_en_de;
        end else if (dp_gnt) begin
            sbox_in       = dp_byte;
            sbox_en_de_in = dp_en_de;
        end
    end

    assign ce = gnt_any;
    assign re = gnt_any;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_vld <= 1'b0;
            lock_ke  <= 1'b0;
            lock_cnt <= 8'd0;
            last_ke  <= 1'b0;
        end else if (gnt_any) begin
            last_ke <= ke_gnt;
            if (gnt_lock) begin
                lock_vld <= 1'b1;
                lock_ke  <= ke_gnt;
                if (lock_vld && lock_ke == ke_gnt)
                    lock_cnt <= (lock_cnt >= MAX_CNT) ? MAX_CNT : lock_cnt + 8'd1;
                else
                    lock_cnt <= 8'd1;
            end else begin
                lock_vld <= 1'b0;
                lock_cnt <= 8'd0;
            end
        end else begin
            lock_vld <= 1'b0;
            lock_cnt <= 8'd0;
        end
    end

    // Tag shift register: stage SBOX_LAT-1 lines up with sbox_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            ke_pipe  <= '0;
        end else begin
            vld_pipe[0] <= gnt_any;
            ke_pipe[0]  <= ke_gnt;
            for (int i = 1; i < SBOX_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                ke_pipe[i]  <= ke_pipe[i-1];
            end
        end
    end

    assign ke_rvalid = rst_n & vld_pipe[SBOX_LAT-1] & ke_pipe[SBOX_LAT-1];
    assign dp_rvalid = rst_n & vld_pipe[SBOX_LAT-1] & ~ke_pipe[SBOX_LAT-1];
    assign ke_rdata  = ke_rvalid ? sbox_out : 8'h00;
    assign dp_rdata  = dp_rvalid ? sbox_out : 8'h00;

endmodule
